// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake
// and holds the fetched word for decode until it is allowed to advance.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      signimm,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic {
        S_REQ   = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_plus4_w;
    logic [31:0]      branch_target_w;
    logic [31:0]      jump_target_w;

    assign pc_plus4_w      = pc_q + 32'd4;
    // Word offset scaled to bytes; the top two offset bits fall off.
    assign branch_target_w = pc_plus4_w + {signimm[29:0], 2'b00};
    assign jump_target_w   = {pc_plus4_w[31:28], jump_index, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            S_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    if (jump) begin
                        pc_d = jump_target_w;
                    end else if (branch_taken) begin
                        pc_d = branch_target_w;
                    end else begin
                        pc_d = pc_plus4_w;
                    end
                    count_d = count_q + CNT_W'(1);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_VALID);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign instr_count = count_q;

endmodule
